// File: rtl/cpu_defs.sv
// cpu_defs: shared multiply/divide op encodings, FSM states and datapath width.
package cpu_defs;
    localparam int MDU_WIDTH = 32;
    typedef enum logic [1:0] {
        MDU_MULT  = 2'b00,
        MDU_MULTU = 2'b01,
        MDU_DIV   = 2'b10,
        MDU_DIVU  = 2'b11
    } mdu_op_t;
    typedef enum logic [2:0] {IDLE, MUL, DIV_RUN, DIV_FIX, DONE} mdu_state_t;
endpackage

// File: rtl/restoring_divider_core.sv
// restoring_divider_core: iterative unsigned divide, one quotient bit per cycle.
module restoring_divider_core #(
    parameter int WIDTH = 32,
    parameter int DIV_ITERS = WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder
);
    localparam int CW = DIV_ITERS > 1 ? $clog2(DIV_ITERS) : 1;
    logic [WIDTH-1:0] q, d;
    logic [WIDTH:0] r;
    logic [WIDTH+1:0] r_sh, diff;
    logic [CW-1:0] count;
    logic active;
    // Quotient bits shift out of q into the remainder; diff's top bit is the trial-subtract borrow.
    assign r_sh = {r, q[WIDTH-1]};
    assign diff = r_sh - {2'b00, d};
    assign done = active && count == CW'(DIV_ITERS - 1);
    assign quotient = q;
    assign remainder = r[WIDTH-1:0];
    always_ff @(posedge clk) begin
        if (rst || abort) begin
            q <= '0;
            d <= '0;
            r <= '0;
            count <= '0;
            active <= 1'b0;
        end else if (start) begin
            q <= dividend;
            d <= divisor;
            r <= '0;
            count <= '0;
            active <= 1'b1;
        end else if (active) begin
            q <= {q[WIDTH-2:0], ~diff[WIDTH+1]};
            r <= diff[WIDTH+1] ? r_sh[WIDTH:0] : diff[WIDTH:0];
            count <= count + 1'b1;
            active <= !done;
        end
    end
endmodule

// File: rtl/hilo_muldiv_unit.sv
// hilo_muldiv_unit: EX-stage MULT/MULTU/DIV/DIVU producing the {hi,lo} result.
// Owns the FSM, sign handling, the multiplier and the output registers.
module hilo_muldiv_unit
    import cpu_defs::*;
#(
    parameter int WIDTH = MDU_WIDTH,
    parameter int DIV_ITERS = WIDTH
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [1:0]         op,
    input  logic [WIDTH-1:0]   src_a,
    input  logic [WIDTH-1:0]   src_b,
    input  logic               flush,
    output logic               busy,
    output logic               hl_valid,
    output logic [2*WIDTH-1:0] hl_data
);
    mdu_state_t state, next;
    logic accept, zero_div, div_start, div_done, msigned, q_neg, r_neg, sdiv;
    logic [WIDTH-1:0] ma, mb, abs_a, abs_b, quotient, remainder, hi_fix, lo_fix;
    logic [2*WIDTH-1:0] prod;
    assign accept = start && !flush && (state == IDLE || state == DONE);
    assign zero_div = src_b == '0;
    assign div_start = accept && op[1] && !zero_div;
    assign sdiv = op == MDU_DIV;
    assign abs_a = (sdiv && src_a[WIDTH-1]) ? -src_a : src_a;
    assign abs_b = (sdiv && src_b[WIDTH-1]) ? -src_b : src_b;
    // Sign- or zero-extend to 2*WIDTH so one unsigned multiply serves both MULT and MULTU.
    assign prod = {{WIDTH{msigned & ma[WIDTH-1]}}, ma} * {{WIDTH{msigned & mb[WIDTH-1]}}, mb};
    assign hi_fix = r_neg ? -remainder : remainder;
    assign lo_fix = q_neg ? -quotient : quotient;
    restoring_divider_core #(.WIDTH(WIDTH), .DIV_ITERS(DIV_ITERS)) u_div (
        .clk(clk),
        .rst(rst),
        .start(div_start),
        .abort(flush),
        .dividend(abs_a),
        .divisor(abs_b),
        .done(div_done),
        .quotient(quotient),
        .remainder(remainder)
    );
    always_comb begin
        next = state;
        case (state)
            IDLE, DONE: next = !accept ? IDLE : !op[1] ? MUL : zero_div ? DONE : DIV_RUN;
            MUL, DIV_FIX: next = DONE;
            DIV_RUN: next = div_done ? DIV_FIX : DIV_RUN;
            default: next = IDLE;
        endcase
        if (flush) next = IDLE;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            busy <= 1'b0;
            hl_valid <= 1'b0;
            hl_data <= '0;
            ma <= '0;
            mb <= '0;
            msigned <= 1'b0;
            q_neg <= 1'b0;
            r_neg <= 1'b0;
        end else begin
            state <= next;
            busy <= next inside {MUL, DIV_RUN, DIV_FIX};
            hl_valid <= next == DONE;
            if (accept) begin
                ma <= src_a;
                mb <= src_b;
                msigned <= op == MDU_MULT;
                q_neg <= sdiv && (src_a[WIDTH-1] ^ src_b[WIDTH-1]);
                r_neg <= sdiv && src_a[WIDTH-1];
            end
            // Entering DONE from IDLE/DONE can only be a divide by zero.
            if (next == DONE)
                hl_data <= state == MUL ? prod : state == DIV_FIX ? {hi_fix, lo_fix} : {src_a, {WIDTH{1'b1}}};
        end
    end
endmodule

// File: tb/tb_hilo_muldiv_unit.sv
// tb_hilo_muldiv_unit: directed vectors with a scoreboard checking result data and latency.
module tb_hilo_muldiv_unit;
    import cpu_defs::*;
    logic clk = 1'b0, rst = 1'b1, start = 1'b0, flush = 1'b0;
    logic [1:0] op = 2'b00;
    logic [31:0] src_a = '0, src_b = '0;
    logic busy, hl_valid;
    logic [63:0] hl_data;
    typedef struct {
        logic [63:0] data;
        int due;
    } exp_t;
    exp_t sb[$];
    int cyc = 0, checks = 0, fails = 0;

    hilo_muldiv_unit dut (
        .clk(clk), .rst(rst), .start(start), .op(op), .src_a(src_a), .src_b(src_b),
        .flush(flush), .busy(busy), .hl_valid(hl_valid), .hl_data(hl_data)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string n, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h required %h", n, got, exp);
        end
    endtask

    always @(negedge clk) begin : monitor
        exp_t e;
        if (!rst && hl_valid) begin
            if (sb.size() == 0) begin
                checks++;
                fails++;
                $display("FAIL unexpected_hl_valid: got data %h at cycle %0d, required no pulse", hl_data, cyc);
            end else begin
                e = sb.pop_front();
                chk("hl_data", hl_data, e.data);
                chk("latency_cycle", 64'(cyc), 64'(e.due));
            end
        end
    end

    task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                         input logic [63:0] d, input int lat, input bit push);
        op = o;
        src_a = a;
        src_b = b;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        if (push) sb.push_back('{d, cyc + lat - 1});
    endtask

    task automatic wait_done();
        int n = 0;
        while (sb.size() != 0 && n < 200) begin
            @(posedge clk);
            n++;
        end
        #1;
        chk("scoreboard_drain", 64'(sb.size()), 64'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        int n;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_busy", 64'(busy), 64'd0);
        chk("reset_hl_valid", 64'(hl_valid), 64'd0);
        chk("reset_hl_data", hl_data, 64'd0);
        rst = 1'b0;

        issue(MDU_MULT, 32'hFFFFFFFE, 32'd3, 64'hFFFFFFFF_FFFFFFFA, 2, 1);
        wait_done();
        issue(MDU_MULTU, 32'hFFFFFFFE, 32'd3, 64'h00000002_FFFFFFFA, 2, 1);
        wait_done();

        issue(MDU_DIVU, 32'd100, 32'd7, {32'd2, 32'd14}, 34, 1);
        n = 0;
        while (busy && n < 100) begin
            n++;
            @(posedge clk);
            #1;
        end
        chk("divu_busy_cycles", 64'(n), 64'd33);
        wait_done();

        issue(MDU_DIV, 32'hFFFFFF9C, 32'd7, {32'hFFFFFFFE, 32'hFFFFFFF2}, 34, 1);
        wait_done();
        issue(MDU_DIV, 32'h80000000, 32'hFFFFFFFF, {32'h0, 32'h80000000}, 34, 1);
        wait_done();
        issue(MDU_DIV, 32'd5, 32'd0, {32'd5, 32'hFFFFFFFF}, 1, 1);
        wait_done();
        issue(MDU_DIVU, 32'd9, 32'd0, {32'd9, 32'hFFFFFFFF}, 1, 1);
        wait_done();

        issue(MDU_DIVU, 32'd100, 32'd7, 64'd0, 0, 0);
        repeat (9) @(posedge clk);
        #1;
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        chk("flush_busy", 64'(busy), 64'd0);
        chk("flush_hl_valid", 64'(hl_valid), 64'd0);
        repeat (40) @(posedge clk);
        #1;
        issue(MDU_MULTU, 32'd6, 32'd7, 64'h00000000_0000002A, 2, 1);
        wait_done();

        issue(MDU_DIV, 32'd100, 32'd7, {32'd2, 32'd14}, 34, 1);
        repeat (5) @(posedge clk);
        #1;
        issue(MDU_MULT, 32'd3, 32'd4, 64'd0, 0, 0);
        wait_done();

        issue(MDU_DIVU, 32'd20, 32'd3, {32'd2, 32'd6}, 34, 1);
        repeat (33) @(posedge clk);
        #1;
        chk("done_cycle_hl_valid", 64'(hl_valid), 64'd1);
        issue(MDU_MULT, 32'd7, 32'hFFFFFFFF, 64'hFFFFFFFF_FFFFFFF9, 2, 1);
        wait_done();

        issue(MDU_DIVU, 32'd1000, 32'd3, 64'd0, 0, 0);
        repeat (5) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_mid_busy", 64'(busy), 64'd0);
        chk("rst_mid_hl_valid", 64'(hl_valid), 64'd0);
        chk("rst_mid_hl_data", hl_data, 64'd0);
        rst = 1'b0;
        repeat (40) @(posedge clk);
        #1;
        chk("final_scoreboard_empty", 64'(sb.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule

// File: doc/hilo_muldiv_unit.md
Name: hilo_muldiv_unit

Overview:
- EX-stage multi-cycle multiply/divide unit for MULT/MULTU/DIV/DIVU.
- Produces the 64-bit {hi,lo} result and its write-enable, which travel down the pipeline as hl_data / hl_write_enable_from_wb into the register file's HI/LO write and forward path.
- Raises busy to stall the front end while a divide iterates.

Parameters:
- WIDTH, 32, operand width; hl_data is 2*WIDTH.
- DIV_ITERS, WIDTH, restoring-divide iterations, one bit per cycle.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  synchronous active-high reset.
- start  in  1  issue request; qualified by op and operands in the same cycle.
- op  in  2  operation: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
- src_a  in  WIDTH  rs value: multiplicand or dividend.
- src_b  in  WIDTH  rt value: multiplier or divisor.
- flush  in  1  exception/pipeline flush; aborts the current operation.
- busy  out  1  operation in flight; upstream must hold and must not issue.
- hl_valid  out  1  one-cycle pulse; hl_data valid this cycle (drives hl_write_enable).
- hl_data  out  2*WIDTH  {hi,lo} result; hi is [63:32], lo is [31:0].

Behaviour:
- Reset (rst=1 at posedge): state=IDLE, busy=0, hl_valid=0, hl_data=0, all internal registers cleared. Overrides flush, start and any state mid-operation.
- States: IDLE, MUL, DIV_RUN, DIV_FIX, DONE.
- Accept: start is accepted only in IDLE or DONE with flush=0. Start in any other state is ignored, with no queuing.
- MULT/MULTU: accept cycle registers the operands; the product is computed during MUL. hl_valid rises the 2nd posedge after acceptance, which gives latency 2.
  - MULT: signed 32x32->64.
  - MULTU: unsigned.
- DIV/DIVU: accept cycle registers |a|, |b| (raw values for DIVU), result-sign flags and count=0.
  - DIV_RUN: one restoring step per cycle (shift remainder, trial subtract, set quotient bit). count increments; leave after count==DIV_ITERS-1.
  - DIV_FIX: negate the quotient if the signs differed (signed only); negate the remainder if the dividend was negative (signed only).
  - Latency: DIV_ITERS+2 cycles from accept to hl_valid, which is 34 cycles at default.
- Divide by zero (src_b==0): skip DIV_RUN and DIV_FIX and go to DONE next cycle, latency 1 cycle. Result is hi=src_a, lo=all ones, for both DIV and DIVU.
- Signed overflow (0x80000000 / 0xFFFFFFFF): no special case; the natural result is lo=0x80000000, hi=0.
- DONE: hl_valid=1 for exactly this cycle, and hl_data holds the result.
  - Without a new start, go to IDLE next cycle.
  - With start, accept it; back-to-back issue is allowed.
  - hl_data holds its last value until overwritten by the next result.
- busy = 1 in MUL, DIV_RUN and DIV_FIX; 0 in IDLE and DONE. busy is registered from the next state, never combinational from start. The issuing stage must insert at least one stall cycle after issue; it reads busy from the cycle after acceptance.
- flush: highest priority after rst. Next state is IDLE, busy=0, hl_valid=0 next cycle. A flush in the same cycle as start discards the start. A flush in the cycle before DONE suppresses that hl_valid. hl_data is not cleared.
- Operand width rules:
  - Signed magnitudes are computed in WIDTH bits; |0x80000000| is 0x80000000 treated as unsigned.
  - The remainder register is WIDTH+1 bits, to hold the trial-subtract borrow.

Decomposition:
- Shared package (cpu_defs): MDU op encodings (MDU_MULT, MDU_MULTU, MDU_DIV, MDU_DIVU), the state enum, and the WIDTH constant.
- One sub-module, restoring_divider_core: holds the iterative unsigned divide datapath (start, dividend, divisor -> done, quotient, remainder).
- The top level owns the FSM, sign handling, the multiply and the output registers.

Test Plan:
- MULT a=0xFFFFFFFE (-2), b=3 -> hl_valid 2 cycles after accept, hl_data=0xFFFFFFFF_FFFFFFFA. MULTU same operands -> 0x00000002_FFFFFFFA.
- DIVU a=100, b=7 -> busy high 33 cycles, hl_valid at cycle 34, hi=2, lo=14. DIV a=-100 (0xFFFFFF9C), b=7 -> hi=0xFFFFFFFE (-2), lo=0xFFFFFFF2 (-14).
- DIV a=0x80000000, b=0xFFFFFFFF -> hi=0, lo=0x80000000; DIV a=5, b=0 -> hl_valid after 1 cycle, hi=5, lo=0xFFFFFFFF.
- flush asserted at cycle 10 of a DIVU -> busy=0 next cycle, no hl_valid pulse ever. A new MULTU 6*7 then returns hl_data=0x00000000_0000002A.
- start pulsed while busy (mid-DIV) with op=MULT -> ignored; only the DIV result appears. start in the DONE cycle -> accepted, and the second result follows with correct latency.
- rst asserted mid-DIV_RUN -> next cycle busy=0, hl_valid=0, hl_data=0.
